ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit, directly upstream of the datapath. It consumes the next-PC value
//  chosen by the next-PC select and holds the architectural PC.
//  It fetches each instruction from instruction memory over a req/ack handshake with
//  variable latency, then presents instr/pc/pc4 to decode and the writeback select.
//  It traps on a misaligned next PC and counts retired instructions.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC loaded on reset; first fetch address
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk          in   1      system clock; all state updates on rising edge
//  reset        in   1      asynchronous, active-low reset (0 = in reset)
//  npc          in   32     next PC from next-PC select; sampled only on an accepted advance
//  advance      in   1      datapath has finished the current instr; move PC to npc
//  im_req       out  1      fetch request to instruction memory
//  im_addr      out  32     fetch byte address (= pc); stable while im_req=1
//  im_ack       in   1      1-cycle pulse; im_rdata valid in same cycle
//  im_rdata     in   32     instruction word from memory
//  pc           out  32     address of current instruction
//  pc4          out  32     pc + 4, combinational, wraps mod 2^32
//  instr        out  32     current instruction word (registered)
//  instr_valid  out  1      instr/pc valid for the datapath
//  fault        out  1      sticky misaligned-fetch trap
//  fault_addr   out  32     offending npc captured at the trap
//  retired      out  CNT_W  count of accepted advances; wraps to 0
// BEHAVIOUR
//  - Reset (reset=0), async, all outputs immediate:
//    state=START, pc=RESET_PC, instr=0, instr_valid=0, fault=0, fault_addr=0, retired=0.
//    im_req=0 because it decodes from state.
//  - States:
//    START: im_req=0; drops any in-flight ack; next cycle -> FETCH.
//    FETCH: im_req=1, im_addr=pc. On im_ack=1: instr<=im_rdata, instr_valid<=1 -> HOLD.
//           With no ack, stay; im_addr is held constant (no timeout).
//    HOLD:  im_req=0, instr_valid=1. On advance=1: pc<=npc, retired<=retired+1, instr_valid<=0.
//           If npc[1:0]==0 -> FETCH, else -> FAULT with fault_addr<=npc.
//    FAULT: im_req=0, instr_valid=0, fault=1; absorbing until reset.
//           pc holds the misaligned npc.
//  - Latency: the earliest instr_valid is the cycle after im_ack.
//    With an ack in the first FETCH cycle, an advance costs at least 2 cycles: HOLD to FETCH to HOLD.
//  - advance is ignored in START, FETCH and FAULT (no pc or counter change).
//    im_ack is ignored outside FETCH.
//  - The misaligned advance still increments retired, because the trapping instruction retired.
//  - pc4 and the counter wrap modulo their width; there is no overflow flag.
//  - instr holds its last value when instr_valid=0; consumers must qualify with instr_valid.
//  - Reset asserted mid-FETCH abandons the fetch. The memory's late ack lands in START and is dropped.
// TESTING
//  T1 release reset, ack in first FETCH cycle with rdata=32'h3C01_1234 ->
//     im_addr=0x3000, then instr=0x3C011234 and instr_valid=1 on the next cycle.
//  T2 in HOLD, advance=1 with npc=pc4=0x3004 ->
//     pc=0x3004, retired=1, instr_valid=0, im_req=1 in the following cycle.
//  T3 ack delayed 3 cycles ->
//     im_req=1 and im_addr=0x3004 stable for 3 cycles, instr_valid=0 throughout.
//  T4 advance with npc=0x0000_3102 ->
//     fault=1, fault_addr=0x3102, im_req=0 forever; later advance and ack have no effect.
//  T5 reset=0 mid-FETCH, ack pulse in the first cycle after release ->
//     outputs at reset values at once; ack ignored; FETCH of 0x3000 then resumes.
//  T6 advance held 1 during FETCH; then npc=0xFFFF_FFFC accepted ->
//     no early advance; after the accepted advance pc4=0x0000_0000.

Source files
------------

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit
//
// Holds the architectural PC and fetches one instruction at a time from
// instruction memory. The memory uses a req/ack handshake with variable
// latency. The fetched word is presented to decode together with pc and
// pc + 4. A misaligned next PC causes a sticky trap. Every accepted advance
// is counted as a retired instruction.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset (0 = in reset)
//   npc          next PC, sampled only on an accepted advance
//   advance      datapath finished the current instruction
//   im_req       fetch request to instruction memory
//   im_addr      fetch byte address (= pc), stable while im_req = 1
//   im_ack       one-cycle acknowledge; im_rdata is valid in the same cycle
//   im_rdata     instruction word from memory
//   pc           address of the current instruction
//   pc4          pc + 4, combinational, wraps modulo 2^32
//   instr        current instruction word (registered)
//   instr_valid  instr and pc are valid for the datapath
//   fault        sticky misaligned-fetch trap
//   fault_addr   offending npc captured at the trap
//   retired      count of accepted advances, wraps to 0
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      npc,
  input  logic             advance,
  output logic             im_req,
  output logic [31:0]      im_addr,
  input  logic             im_ack,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg;
  logic [31:0]        instr_reg;
  logic [31:0]        fault_addr_reg;
  logic [CNT_W-1:0]   retired_reg;

  logic               load_instr;  // accept the memory word this cycle
  logic               take_adv;    // accept an advance this cycle
  logic               misaligned;

  assign misaligned = (npc[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= START;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. The datapath registers below follow the strobes
  // produced here, so advance and im_ack are only honoured in the
  // states where they are meaningful.
  always_comb begin
    state_next = state_reg;
    load_instr = 1'b0;
    take_adv   = 1'b0;
    case (state_reg)
      START: begin
        // One idle cycle after reset. An ack still in flight from a fetch
        // abandoned by reset lands here and is dropped.
        state_next = FETCH;
      end
      FETCH: begin
        if (im_ack) begin
          load_instr = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          take_adv   = 1'b1;
          state_next = misaligned ? FAULT : FETCH;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = START;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg         <= RESET_PC;
      instr_reg      <= 32'd0;
      fault_addr_reg <= 32'd0;
      retired_reg    <= '0;
    end else begin
      if (load_instr) begin
        instr_reg <= im_rdata;
      end
      if (take_adv) begin
        // A trapping advance still moves pc and counts as retired: the
        // trapping instruction did complete.
        pc_reg      <= npc;
        retired_reg <= retired_reg + CNT_W'(1);
        if (misaligned) begin
          fault_addr_reg <= npc;
        end
      end
    end
  end

  // Handshake and status outputs decode directly from the state, so they
  // take their reset values as soon as reset is asserted.
  assign im_req      = (state_reg == FETCH);
  assign instr_valid = (state_reg == HOLD);
  assign fault       = (state_reg == FAULT);
  assign im_addr     = pc_reg;
  assign pc          = pc_reg;
  assign pc4         = pc_reg + 32'd4;
  assign instr       = instr_reg;
  assign fault_addr  = fault_addr_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch -- self-checking bench for ifu_fetch
//
// A driver applies directed and random stimulus on the falling edge. A
// behavioural model tracks what the fetch unit should be doing: idle after
// reset, waiting on memory, holding an instruction, or trapped. Each
// instruction the model expects to be presented is pushed into a
// scoreboard queue, along with each expected trap. A separate monitor pops
// and compares whenever the DUT raises instr_valid or fault.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc = 32'd0;
  logic        advance = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] retired;

  ifu_fetch #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .advance    (advance),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .pc         (pc),
    .pc4        (pc4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fault      (fault),
    .fault_addr (fault_addr),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Scoreboard entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } txn_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] ret;
  } flt_t;

  txn_t exp_q[$];
  flt_t flt_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the unit is doing right now.
  localparam int P_IDLE  = 0;  // first cycle after reset, no request
  localparam int P_WAIT  = 1;  // waiting on memory
  localparam int P_HAVE  = 2;  // instruction presented to datapath
  localparam int P_TRAP  = 3;  // trapped on misaligned PC

  int          m_phase = P_IDLE;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_ret   = 32'd0;

  // One clock cycle: check the cycle-level outputs against the model,
  // drive the inputs for the coming edge, then advance the model.
  task automatic step(input logic ack, input logic [31:0] rdata,
                      input logic adv, input logic [31:0] n);
    chk("im_req",      32'(im_req),      32'(m_phase == P_WAIT));
    chk("instr_valid", 32'(instr_valid), 32'(m_phase == P_HAVE));
    chk("fault",       32'(fault),       32'(m_phase == P_TRAP));
    chk("pc",          pc,               m_pc);
    chk("retired",     retired,          m_ret);
    if (m_phase == P_WAIT) chk("im_addr", im_addr, m_pc);

    im_ack   = ack;
    im_rdata = rdata;
    advance  = adv;
    npc      = n;

    case (m_phase)
      P_IDLE: m_phase = P_WAIT;
      P_WAIT: if (ack) begin
        exp_q.push_back('{pc: m_pc, instr: rdata, ret: m_ret});
        m_phase = P_HAVE;
      end
      P_HAVE: if (adv) begin
        m_ret = m_ret + 32'd1;
        m_pc  = n;
        if (n % 4 == 0) begin
          m_phase = P_WAIT;
        end else begin
          flt_q.push_back('{addr: n, ret: m_ret});
          m_phase = P_TRAP;
        end
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  // Assert reset part-way through a cycle, check the outputs respond at
  // once, hold it to the next falling edge and release.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_im_req",      32'(im_req),      32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault",       32'(fault),       32'd0);
    chk("rst_fault_addr",  fault_addr,       32'd0);
    chk("rst_retired",     retired,          32'd0);
    chk("rst_pc",          pc,               RESET_PC);
    chk("rst_instr",       instr,            32'd0);
    exp_q.delete();
    flt_q.delete();
    m_phase = P_IDLE;
    m_pc    = RESET_PC;
    m_ret   = 32'd0;
    im_ack  = 1'b0;
    advance = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  // Monitor: compare each presented instruction and each trap with the
  // scoreboard.
  logic mon_prev_valid = 1'b0;
  logic mon_prev_fault = 1'b0;

  initial begin
    txn_t t;
    flt_t f;
    forever begin
      @(negedge clk);
      if (instr_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc=%h instr=%h expected none", pc, instr);
        end else begin
          t = exp_q.pop_front();
          chk("txn_pc",      pc,      t.pc);
          chk("txn_instr",   instr,   t.instr);
          chk("txn_pc4",     pc4,     t.pc + 32'd4);
          chk("txn_retired", retired, t.ret);
          $display("instr pc=%h instr=%h pc4=%h retired=%0d", pc, instr, pc4, retired);
        end
      end
      if (fault && !mon_prev_fault) begin
        if (flt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fault: got fault_addr=%h expected none", fault_addr);
        end else begin
          f = flt_q.pop_front();
          chk("trap_addr",    fault_addr, f.addr);
          chk("trap_pc",      pc,         f.addr);
          chk("trap_retired", retired,    f.ret);
          $display("trap fault_addr=%h retired=%0d", fault_addr, retired);
        end
      end
      mon_prev_valid = instr_valid;
      mon_prev_fault = fault;
    end
  end

  initial begin
    logic [31:0] n;
    logic [31:0] r;
    @(negedge clk);
    do_reset();

    // T5 (part) / T1: ack in the idle cycle is dropped; ack in first
    // request cycle delivers 0x3C011234 from 0x3000.
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
    step(1'b1, 32'h3C01_1234, 1'b0, 32'd0);
    // T2: advance to pc4.
    step(1'b0, 32'd0, 1'b1, 32'h0000_3004);
    // T3 / T6: memory stalls 3 cycles while advance is held high.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 32'h5555_5555);
    step(1'b1, 32'h1111_2222, 1'b1, 32'h5555_5555);
    // T6: advance to the top of the address space, pc4 wraps.
    step(1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 32'h3333_4444, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 32'h0000_3100);
    step(1'b1, 32'h5555_6666, 1'b0, 32'd0);
    // T4: misaligned advance traps; later activity has no effect.
    step(1'b0, 32'd0, 1'b1, 32'h0000_3102);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h7777_8888, 1'b1, 32'h0000_4000);
    // T5: reset during a fetch, then a late ack in the idle cycle.
    do_reset();
    step(1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b0, 32'd0);
    do_reset();
    step(1'b1, 32'hBAD0_BAD0, 1'b0, 32'd0);
    step(1'b1, 32'h0123_4567, 1'b0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == P_TRAP && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else if (m_phase == P_WAIT && $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 5) begin
          n = m_pc + 32'd4 + 32'($urandom_range(1, 3));
        end else if (r < 80) begin
          n = m_pc + 32'd4;
        end else begin
          n = $urandom;
          n[1:0] = 2'b00;
        end
        step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1, n);
      end
    end

    step(1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("instr_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("trap_queue_drained",  32'(flt_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
